// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, writeback-select codes and parameter bound helpers.
package hazard_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_LOAD_STALL,
        ST_FLUSH,
        ST_MEM_WAIT,
        ST_HALTED
    } hz_state_e;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;

    // Load-use bubbles are limited to 1..3 so the wait counter fits in two bits.
    function automatic int bound_lsc(input int n);
        if (n < 1) return 1;
        if (n > 3) return 3;
        return n;
    endfunction

    function automatic int bound_min1(input int n);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Hazard controller bundle: pipeline observation inputs and pipeline-register controls.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_if #(parameter int CNT_W = 16);
    logic [4:0]       Rs1_D, Rs2_D;
    logic             Rs1Used_D, Rs2Used_D;
    logic [4:0]       Rdst_E, Rdst_M;
    logic             RegWrEn_E, RegWrEn_M;
    logic [1:0]       WBSel_E, WBSel_M;
    logic             BranchTaken_E;
    logic             MemBusy_M;
    logic             halt_W;

    logic             stall_F, stall_FD, stall_DE;
    logic             nop_FD, nop_DE, nop_EM;
    logic             hold_MW;
    logic             FF_EX_APPLICABLE, FF_MEM_APPLICABLE;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    modport master (
        output Rs1_D, Rs2_D, Rs1Used_D, Rs2Used_D, Rdst_E, Rdst_M,
               RegWrEn_E, RegWrEn_M, WBSel_E, WBSel_M, BranchTaken_E, MemBusy_M, halt_W,
        input  stall_F, stall_FD, stall_DE, nop_FD, nop_DE, nop_EM, hold_MW,
               FF_EX_APPLICABLE, FF_MEM_APPLICABLE, halted, mem_timeout,
               stall_cycles, flush_count
    );

    modport slave (
        input  Rs1_D, Rs2_D, Rs1Used_D, Rs2Used_D, Rdst_E, Rdst_M,
               RegWrEn_E, RegWrEn_M, WBSel_E, WBSel_M, BranchTaken_E, MemBusy_M, halt_W,
        output stall_F, stall_FD, stall_DE, nop_FD, nop_DE, nop_EM, hold_MW,
               FF_EX_APPLICABLE, FF_MEM_APPLICABLE, halted, mem_timeout,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_match.sv
// Producer qualification and source-register compare for one pipeline stage.
// hit = stage writes a non-x0 register that Decode actually reads.
module hazard_match (
    input  logic [4:0] rdst,
    input  logic       wr_en_n,
    input  logic [4:0] rs1,
    input  logic       rs1_used,
    input  logic [4:0] rs2,
    input  logic       rs2_used,
    output logic       hit
);
    logic producer;

    assign producer = !wr_en_n && (rdst != 5'd0);
    assign hit      = producer && ((rs1_used && (rdst == rs1)) || (rs2_used && (rdst == rs2)));
endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stalls, branch flush, memory-wait hold, halt freeze.
// Optional HAZARD_PERF_CNT_EN builds the saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_WAIT_MAX      = 15,
    parameter int CNT_W             = 16
) (
    input logic     CLK,
    input logic     RST,
    hazard_if.slave hz
);
    localparam int               LSC       = bound_lsc(LOAD_STALL_CYCLES);
    localparam int               MWM       = bound_min1(MEM_WAIT_MAX);
    localparam int               BW        = $clog2(MWM + 1);
    localparam logic [1:0]       LS_INIT   = 2'(LSC - 1);
    localparam logic [BW-1:0]    BUSY_LAST = BW'(MWM - 1);

    hz_state_e     state;
    logic [1:0]    ls_cnt;
    logic [BW-1:0] busy_cnt;
    logic          stall_f, stall_fd, stall_de, nop_fd, nop_de, hold_mw;
    logic          ff_ex, ff_mem, halted, mem_timeout;
    logic          hit_e, hit_m, load_use, fwd_ex, resume;

    hazard_match u_match_e (
        .rdst(hz.Rdst_E), .wr_en_n(hz.RegWrEn_E),
        .rs1(hz.Rs1_D), .rs1_used(hz.Rs1Used_D),
        .rs2(hz.Rs2_D), .rs2_used(hz.Rs2Used_D),
        .hit(hit_e)
    );

    hazard_match u_match_m (
        .rdst(hz.Rdst_M), .wr_en_n(hz.RegWrEn_M),
        .rs1(hz.Rs1_D), .rs1_used(hz.Rs1Used_D),
        .rs2(hz.Rs2_D), .rs2_used(hz.Rs2Used_D),
        .hit(hit_m)
    );

    assign load_use = hit_e && (hz.WBSel_E == WB_MEM);
    assign fwd_ex   = hit_e && (hz.WBSel_E != WB_MEM);
    // A memory wait that interrupted a multi-cycle load stall picks the count back up.
    assign resume   = (state == ST_LOAD_STALL) || ((state == ST_MEM_WAIT) && (ls_cnt != 2'd0));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= ST_RUN;
            ls_cnt      <= 2'd0;
            busy_cnt    <= '0;
            stall_f     <= 1'b0;
            stall_fd    <= 1'b0;
            stall_de    <= 1'b0;
            nop_fd      <= 1'b0;
            nop_de      <= 1'b0;
            hold_mw     <= 1'b0;
            ff_ex       <= 1'b1;
            ff_mem      <= 1'b1;
            halted      <= 1'b0;
            mem_timeout <= 1'b0;
        end else if (state != ST_HALTED) begin
            {stall_f, stall_fd, stall_de, nop_fd, nop_de, hold_mw} <= '0;
            ff_ex  <= !fwd_ex;
            ff_mem <= !hit_m;
            if (hz.halt_W || (hz.MemBusy_M && (busy_cnt == BUSY_LAST))) begin
                state  <= ST_HALTED;
                {stall_f, stall_fd, stall_de, hold_mw} <= '1;
                halted <= 1'b1;
                ff_ex  <= 1'b1;
                ff_mem <= 1'b1;
                if (!hz.halt_W) mem_timeout <= 1'b1;
            end else if (hz.MemBusy_M) begin
                state    <= ST_MEM_WAIT;
                busy_cnt <= busy_cnt + 1'b1;
                {stall_f, stall_fd, stall_de, hold_mw} <= '1;
            end else begin
                busy_cnt <= '0;
                state    <= ST_RUN;
                // The cycle after a flush sees a squashed Decode instruction, so nothing is acted on.
                if (state != ST_FLUSH) begin
                    if (hz.BranchTaken_E) begin
                        state  <= ST_FLUSH;
                        nop_fd <= 1'b1;
                        nop_de <= 1'b1;
                        ls_cnt <= 2'd0;
                    end else if (resume) begin
                        {stall_f, stall_fd, nop_de} <= '1;
                        ls_cnt <= ls_cnt - 1'b1;
                        if (ls_cnt != 2'd1) state <= ST_LOAD_STALL;
                    end else if (load_use) begin
                        {stall_f, stall_fd, nop_de} <= '1;
                        ls_cnt <= LS_INIT;
                        if (LS_INIT != 2'd0) state <= ST_LOAD_STALL;
                    end
                end
            end
        end
    end

    assign hz.stall_F           = stall_f;
    assign hz.stall_FD          = stall_fd;
    assign hz.stall_DE          = stall_de;
    assign hz.nop_FD            = nop_fd;
    assign hz.nop_DE            = nop_de;
    // No hazard in this pipeline needs a bubble into EX/MEM.
    assign hz.nop_EM            = 1'b0;
    assign hz.hold_MW           = hold_mw;
    assign hz.FF_EX_APPLICABLE  = ff_ex;
    assign hz.FF_MEM_APPLICABLE = ff_mem;
    assign hz.halted            = halted;
    assign hz.mem_timeout       = mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // Counts completed cycles: a cycle is tallied at the edge that ends it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f && (state != ST_HALTED) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if ((state == ST_FLUSH) && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_count  = flush_cnt;
`else
    assign hz.stall_cycles = {CNT_W{1'b0}};
    assign hz.flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances with LOAD_STALL_CYCLES = 1, 2, 3 share stimulus.
// Table vectors cover single-edge decisions; hand sequences cover stalls, flush, waits, halt and reset.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int CW = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {stall_F, stall_FD, stall_DE, nop_FD, nop_DE, nop_EM, hold_MW, FF_EX, FF_MEM, halted, mem_timeout}
    localparam logic [10:0] E_IDLE = 11'b000_000_0_11_00;
    localparam logic [10:0] E_LU   = 11'b110_010_0_11_00;
    localparam logic [10:0] E_MW   = 11'b111_000_1_11_00;
    localparam logic [10:0] E_HALT = 11'b111_000_1_11_10;
    localparam logic [10:0] E_TO   = 11'b111_000_1_11_11;
    localparam logic [10:0] E_BR   = 11'b000_110_0_11_00;

    typedef struct packed {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rde, rdm;
        logic       we, wm;
        logic [1:0] wbe, wbm;
        logic       br, busy, halt;
    } in_t;

    typedef struct {
        in_t         in;
        logic [10:0] exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    in_t         cur;
    logic [10:0] obs  [3];
    logic [CW-1:0] scyc [3];
    logic [CW-1:0] fcnt [3];
    int          checks = 0;
    int          failures = 0;
    vec_t        tbl [13];

    always #5 CLK = ~CLK;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            hazard_if #(.CNT_W(CW)) hz ();
            assign hz.Rs1_D         = cur.rs1;
            assign hz.Rs2_D         = cur.rs2;
            assign hz.Rs1Used_D     = cur.u1;
            assign hz.Rs2Used_D     = cur.u2;
            assign hz.Rdst_E        = cur.rde;
            assign hz.Rdst_M        = cur.rdm;
            assign hz.RegWrEn_E     = cur.we;
            assign hz.RegWrEn_M     = cur.wm;
            assign hz.WBSel_E       = cur.wbe;
            assign hz.WBSel_M       = cur.wbm;
            assign hz.BranchTaken_E = cur.br;
            assign hz.MemBusy_M     = cur.busy;
            assign hz.halt_W        = cur.halt;
            assign obs[g] = {hz.stall_F, hz.stall_FD, hz.stall_DE, hz.nop_FD, hz.nop_DE, hz.nop_EM,
                             hz.hold_MW, hz.FF_EX_APPLICABLE, hz.FF_MEM_APPLICABLE, hz.halted,
                             hz.mem_timeout};
            assign scyc[g] = hz.stall_cycles;
            assign fcnt[g] = hz.flush_count;
            hazard_ctrl #(.LOAD_STALL_CYCLES(g + 1), .MEM_WAIT_MAX(15), .CNT_W(CW)) u_dut (
                .CLK(CLK), .RST(RST), .hz(hz)
            );
        end
    endgenerate

    function automatic in_t mi(int rs1, int u1, int rs2, int u2, int rde, int we, logic [1:0] wbe,
                               int rdm, int wm, logic [1:0] wbm, int busy);
        in_t r;
        r.rs1 = 5'(rs1);  r.u1 = 1'(u1);
        r.rs2 = 5'(rs2);  r.u2 = 1'(u2);
        r.rde = 5'(rde);  r.we = 1'(we);  r.wbe = wbe;
        r.rdm = 5'(rdm);  r.wm = 1'(wm);  r.wbm = wbm;
        r.br = 1'b0;  r.busy = 1'(busy);  r.halt = 1'b0;
        return r;
    endfunction

    function automatic logic [15:0] ec(int n);
        return PERF ? 16'(n) : 16'd0;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        cur = mi(0, 0, 0, 0, 0, 1, WB_ALU, 0, 1, WB_ALU, 0);
        step();
        RST = 1'b1;
    endtask

    in_t idle, lw;

    initial begin
        idle = mi(0, 0, 0, 0, 0, 1, WB_ALU, 0, 1, WB_ALU, 0);
        lw   = mi(5, 1, 0, 0, 5, 0, WB_MEM, 0, 1, WB_ALU, 0);
        tbl[0]  = '{idle, E_IDLE};
        tbl[1]  = '{lw, E_LU};
        tbl[2]  = '{mi(0, 0, 7, 1, 7, 0, WB_ALU, 7, 0, WB_ALU, 0), 11'b000_000_0_00_00};
        tbl[3]  = '{mi(0, 1, 0, 1, 0, 0, WB_ALU, 0, 0, WB_ALU, 0), E_IDLE};
        tbl[4]  = '{mi(0, 0, 7, 0, 7, 0, WB_ALU, 7, 0, WB_ALU, 0), E_IDLE};
        tbl[5]  = '{mi(7, 1, 0, 0, 7, 1, WB_MEM, 0, 1, WB_ALU, 0), E_IDLE};
        tbl[6]  = '{mi(3, 1, 0, 0, 0, 1, WB_ALU, 3, 0, WB_MEM, 0), 11'b000_000_0_10_00};
        tbl[7]  = '{mi(0, 0, 9, 1, 9, 0, WB_MEM, 0, 1, WB_ALU, 0), E_LU};
        tbl[8]  = '{mi(0, 0, 0, 0, 0, 1, WB_ALU, 0, 1, WB_ALU, 1), E_MW};
        tbl[9]  = '{idle, E_IDLE};
        tbl[10] = '{mi(4, 1, 0, 0, 4, 0, WB_ALU, 0, 1, WB_ALU, 1), 11'b111_000_1_01_00};
        tbl[11] = '{mi(9, 1, 0, 0, 9, 0, WB_ALU, 0, 1, WB_ALU, 0), 11'b000_000_0_01_00};
        tbl[12] = '{mi(6, 1, 0, 0, 6, 0, WB_MEM, 6, 0, WB_ALU, 0), 11'b110_010_0_10_00};

        // reset state of every instance
        do_reset();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_out[%0d]", d), 16'(obs[d]), 16'(E_IDLE));
            chk($sformatf("reset_scyc[%0d]", d), 16'(scyc[d]), 16'd0);
            chk($sformatf("reset_fcnt[%0d]", d), 16'(fcnt[d]), 16'd0);
        end

        for (int k = 0; k < 13; k++) begin
            cur = tbl[k].in;
            step();
            chk($sformatf("vec%0d", k), 16'(obs[0]), 16'(tbl[k].exp));
        end

        // load-use bubble length follows LOAD_STALL_CYCLES
        do_reset();
        cur = lw;
        step();
        for (int d = 0; d < 3; d++) chk($sformatf("lu_e0[%0d]", d), 16'(obs[d]), 16'(E_LU));
        cur = idle;
        for (int k = 1; k < 4; k++) begin
            step();
            for (int d = 0; d < 3; d++)
                chk($sformatf("lu_e%0d[%0d]", k, d), 16'(obs[d]), 16'((k < d + 1) ? E_LU : E_IDLE));
        end
        for (int d = 0; d < 3; d++) chk($sformatf("lu_scyc[%0d]", d), 16'(scyc[d]), ec(d + 1));

        // branch coincident with load-use: flush wins, no stall
        do_reset();
        cur = lw;
        cur.br = 1'b1;
        step();
        chk("br_nop", 16'(obs[0]), 16'(E_BR));
        chk("br_nop_lsc3", 16'(obs[2]), 16'(E_BR));
        step();
        chk("br_squash", 16'(obs[0]), 16'(E_IDLE));
        cur = idle;
        step();
        chk("br_idle", 16'(obs[0]), 16'(E_IDLE));
        chk("br_fcnt", 16'(fcnt[0]), ec(1));
        chk("br_scyc", 16'(scyc[0]), 16'd0);

        // three-cycle memory wait
        do_reset();
        cur = idle;
        cur.busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("mw%0d", k), 16'(obs[0]), 16'(E_MW));
        end
        cur.busy = 1'b0;
        step();
        chk("mw_exit", 16'(obs[0]), 16'(E_IDLE));
        chk("mw_scyc", 16'(scyc[0]), ec(3));

        // memory wait inside a 3-cycle load stall resumes the remaining bubbles
        do_reset();
        cur = lw;
        step();
        chk("rs_lu", 16'(obs[2]), 16'(E_LU));
        cur = idle;
        cur.busy = 1'b1;
        step();
        chk("rs_mw0", 16'(obs[2]), 16'(E_MW));
        step();
        chk("rs_mw1", 16'(obs[2]), 16'(E_MW));
        cur.busy = 1'b0;
        step();
        chk("rs_lu1", 16'(obs[2]), 16'(E_LU));
        step();
        chk("rs_lu2", 16'(obs[2]), 16'(E_LU));
        step();
        chk("rs_done", 16'(obs[2]), 16'(E_IDLE));
        chk("rs_scyc", 16'(scyc[2]), ec(5));

        // 15 consecutive busy cycles time out into HALTED
        do_reset();
        cur = idle;
        cur.busy = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            chk($sformatf("to%0d", k), 16'(obs[0]), 16'((k == 14) ? E_TO : E_MW));
        end
        cur = lw;
        cur.br = 1'b1;
        step();
        step();
        chk("to_sticky", 16'(obs[0]), 16'(E_TO));
        chk("to_scyc", 16'(scyc[0]), ec(14));

        // halt pulse freezes, reset recovers
        do_reset();
        cur = idle;
        cur.halt = 1'b1;
        step();
        chk("halt", 16'(obs[0]), 16'(E_HALT));
        cur = lw;
        cur.br = 1'b1;
        step();
        chk("halt_sticky0", 16'(obs[0]), 16'(E_HALT));
        step();
        chk("halt_sticky1", 16'(obs[0]), 16'(E_HALT));
        RST = 1'b0;
        cur = idle;
        step();
        chk("halt_rst", 16'(obs[0]), 16'(E_IDLE));
        RST = 1'b1;
        step();
        chk("halt_run", 16'(obs[0]), 16'(E_IDLE));

        // reset in the middle of a 3-cycle load stall
        do_reset();
        cur = lw;
        step();
        cur = idle;
        step();
        chk("ls_mid", 16'(obs[2]), 16'(E_LU));
        RST = 1'b0;
        step();
        chk("ls_rst", 16'(obs[2]), 16'(E_IDLE));
        chk("ls_rst_scyc", 16'(scyc[2]), 16'd0);
        RST = 1'b1;
        step();
        chk("ls_rst_run", 16'(obs[2]), 16'(E_IDLE));

        // stall counter saturates at all-ones
        do_reset();
        cur = lw;
        for (int k = 0; k < 20; k++) step();
        chk("sat_scyc", 16'(scyc[0]), ec(15));
        chk("sat_out", 16'(obs[0]), 16'(E_LU));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
